mult_div_ctrl: RTL and testbench

- Sequencer for the HI/LO multiply register.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage and computes results iteratively (32-cycle shift-add multiply, 32-cycle restoring divide).
- Drives the single-cycle HI/LO write port with both halves.
- Stalls MFHI/MFLO readers while an operation is in flight.

---
 rtl/mips_pkg.sv | 9 +
 rtl/md_iter_unit.sv | 21 ++
 rtl/mult_div_ctrl.sv | 115 +++++++++++
 tb/tb_mult_div_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the HI/LO multiply/divide sequencer
package mips_pkg;
    localparam int MD_DATA_W = 32;
    localparam int MD_ITER = MD_DATA_W;
    typedef enum logic [2:0] {
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
    } md_op_e;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/md_iter_unit.sv
// md_iter_unit: one shift-add multiply or restoring-divide step on the {hi,lo} accumulator
module md_iter_unit #(
    parameter int DATA_W = 32
) (
    input  logic              is_div,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic [DATA_W-1:0] opnd,
    output logic [DATA_W-1:0] nxt_hi,
    output logic [DATA_W-1:0] nxt_lo
);
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shl;
    logic [DATA_W+1:0] diff;
    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign shl  = {acc_hi, acc_lo[DATA_W-1]};
    // remainder never exceeds the divisor, so a non-negative difference fits in DATA_W bits
    assign diff = {1'b0, shl} - {2'b00, opnd};
    assign nxt_hi = is_div ? (diff[DATA_W+1] ? shl[DATA_W-1:0] : diff[DATA_W-1:0]) : sum[DATA_W:1];
    assign nxt_lo = is_div ? {acc_lo[DATA_W-2:0], ~diff[DATA_W+1]} : {sum[0], acc_lo[DATA_W-1:1]};
endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: HI/LO multiply/divide sequencer with pipeline stall
// MIPS_MULT_FAST_EN selects a single-cycle combinational multiply; default is iterative.
module mult_div_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              md_start,
    input  md_op_e            md_op,
    input  logic [DATA_W-1:0] md_rs,
    input  logic [DATA_W-1:0] md_rt,
    input  logic              hilo_read,
    input  logic [DATA_W-1:0] mult_val_low,
    input  logic [DATA_W-1:0] mult_val_high,
    output logic [DATA_W-1:0] reg_file_mult_data_low,
    output logic [DATA_W-1:0] reg_file_mult_data_high,
    output logic              reg_file_mult_write,
    output logic              md_busy,
    output logic              md_stall
);
    md_state_e             state;
    logic [ITER_CNT_W-1:0] cnt;
    logic [DATA_W-1:0]     acc_hi, acc_lo, opnd, nxt_hi, nxt_lo, abs_rs, abs_rt, q_fix, r_fix;
    logic [2*DATA_W-1:0]   prod_fix;
    logic                  is_div, neg_q, neg_r, is_signed, is_arith;
    assign is_signed = md_op == MD_MULT || md_op == MD_DIV;
    assign is_arith  = md_op == MD_MULT || md_op == MD_MULTU || md_op == MD_DIV || md_op == MD_DIVU;
    assign abs_rs    = is_signed && md_rs[DATA_W-1] ? -md_rs : md_rs;
    assign abs_rt    = is_signed && md_rt[DATA_W-1] ? -md_rt : md_rt;
    assign prod_fix  = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
    assign q_fix     = neg_q ? -nxt_lo : nxt_lo;
    assign r_fix     = neg_r ? -nxt_hi : nxt_hi;
    assign md_stall  = (hilo_read & (md_busy | md_start)) | (md_start & md_busy);
`ifdef MIPS_MULT_FAST_EN
    logic [2*DATA_W-1:0] ext_rs, ext_rt, fast_prod;
    assign ext_rs    = {{DATA_W{is_signed & md_rs[DATA_W-1]}}, md_rs};
    assign ext_rt    = {{DATA_W{is_signed & md_rt[DATA_W-1]}}, md_rt};
    assign fast_prod = ext_rs * ext_rt;
`endif
    md_iter_unit #(.DATA_W(DATA_W)) u_iter (
        .is_div(is_div),
        .acc_hi(acc_hi),
        .acc_lo(acc_lo),
        .opnd(opnd),
        .nxt_hi(nxt_hi),
        .nxt_lo(nxt_lo)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= MD_IDLE;
            cnt                     <= '0;
            acc_hi                  <= '0;
            acc_lo                  <= '0;
            opnd                    <= '0;
            is_div                  <= 1'b0;
            neg_q                   <= 1'b0;
            neg_r                   <= 1'b0;
            reg_file_mult_data_low  <= '0;
            reg_file_mult_data_high <= '0;
            reg_file_mult_write     <= 1'b0;
            md_busy                 <= 1'b0;
        end else begin
            reg_file_mult_write <= 1'b0;
            case (state)
                MD_IDLE: if (md_start) begin
                    if (md_op == MD_MTHI || md_op == MD_MTLO) begin
                        reg_file_mult_data_high <= md_op == MD_MTHI ? md_rs : mult_val_high;
                        reg_file_mult_data_low  <= md_op == MD_MTLO ? md_rs : mult_val_low;
                        reg_file_mult_write     <= 1'b1;
                        md_busy                 <= 1'b1;
                        state                   <= MD_DONE;
                    end
`ifdef MIPS_MULT_FAST_EN
                    else if (md_op == MD_MULT || md_op == MD_MULTU) begin
                        {reg_file_mult_data_high, reg_file_mult_data_low} <= fast_prod;
                        reg_file_mult_write <= 1'b1;
                        md_busy             <= 1'b1;
                        state               <= MD_DONE;
                    end
`endif
                    else if (is_arith) begin
                        acc_hi  <= '0;
                        acc_lo  <= abs_rs;
                        opnd    <= abs_rt;
                        is_div  <= md_op == MD_DIV || md_op == MD_DIVU;
                        neg_q   <= is_signed & (md_rs[DATA_W-1] ^ md_rt[DATA_W-1]);
                        neg_r   <= is_signed & md_rs[DATA_W-1];
                        cnt     <= '0;
                        md_busy <= 1'b1;
                        state   <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    // the last step's result goes straight through sign fix-up into the write port
                    if (cnt == ITER_CNT_W'(MD_ITER - 1)) begin
                        {reg_file_mult_data_high, reg_file_mult_data_low} <= is_div ? {r_fix, q_fix} : prod_fix;
                        reg_file_mult_write <= 1'b1;
                        state               <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    md_busy <= 1'b0;
                    state   <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: directed and modelled checks of the HI/LO multiply/divide sequencer
module tb_mult_div_ctrl;
    import mips_pkg::*;
`ifdef MIPS_MULT_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    logic        clk = 1'b0, rst = 1'b1, md_start = 1'b0, hilo_read = 1'b0;
    md_op_e      md_op = MD_MULTU;
    logic [31:0] md_rs = '0, md_rt = '0, mult_val_low = '0, mult_val_high = '0;
    logic [31:0] data_low, data_high;
    logic        wr, md_busy, md_stall;
    logic [63:0] sb[$];
    logic [63:0] e;
    int          checks = 0, errors = 0, wr_cnt = 0, base;

    mult_div_ctrl #(.DATA_W(32), .ITER_CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .md_start(md_start),
        .md_op(md_op),
        .md_rs(md_rs),
        .md_rt(md_rt),
        .hilo_read(hilo_read),
        .mult_val_low(mult_val_low),
        .mult_val_high(mult_val_high),
        .reg_file_mult_data_low(data_low),
        .reg_file_mult_data_high(data_high),
        .reg_file_mult_write(wr),
        .md_busy(md_busy),
        .md_stall(md_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (wr) wr_cnt++;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(md_op_e op, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb_;
        sa  = 64'($signed(a));
        sb_ = 64'($signed(b));
        case (op)
            MD_MULT:  return sa * sb_;
            MD_MULTU: return {32'd0, a} * {32'd0, b};
            MD_DIV:   return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            default:  return {a % b, a / b};
        endcase
    endfunction

    task automatic run_op(string tag, md_op_e op, logic [31:0] a, logic [31:0] b, int lat, logic [63:0] exp);
        int n;
        sb.push_back(exp);
        md_op = op;
        md_rs = a;
        md_rt = b;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        n = 1;
        chk({tag, "_busy_first"}, 64'(md_busy), 64'd1);
        while (!wr && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_write"}, 64'(wr), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_busy_done"}, 64'(md_busy), 64'd1);
        e = sb.pop_front();
        chk({tag, "_hi"}, 64'(data_high), 64'(e[63:32]));
        chk({tag, "_lo"}, 64'(data_low), 64'(e[31:0]));
        @(negedge clk);
        chk({tag, "_write_once"}, 64'(wr), 64'd0);
        chk({tag, "_busy_after"}, 64'(md_busy), 64'd0);
    endtask

    initial begin
        md_op_e      op;
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_write", 64'(wr), 64'd0);
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_stall", 64'(md_stall), 64'd0);
        chk("rst_hi", 64'(data_high), 64'd0);
        chk("rst_lo", 64'(data_low), 64'd0);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 64'h0000_0001_FFFF_FFFE);
        run_op("mult_neg", MD_MULT, -32'sd3, 32'd5, MUL_LAT, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_neg", MD_DIV, -32'sd7, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", MD_DIVU, 32'd100, 32'd0, 33, 64'h0000_0064_FFFF_FFFF);
        run_op("div_zero", MD_DIV, -32'sd7, 32'd0, 33, 64'hFFFF_FFF9_0000_0001);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000);
        mult_val_low  = 32'hAAAA;
        mult_val_high = 32'h5555;
        run_op("mthi", MD_MTHI, 32'h1234, 32'd0, 1, 64'h0000_1234_0000_AAAA);
        run_op("mtlo", MD_MTLO, 32'h5678, 32'd0, 1, 64'h0000_5555_0000_5678);

        for (int i = 0; i < 6; i++) begin
            op = md_op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (b == 0) b = 32'd1;
            if (i == 2) b = b >> 20;
            run_op("rand", op, a, b, (op == MD_MULT || op == MD_MULTU) ? MUL_LAT : 33, ref_md(op, a, b));
        end

        base = wr_cnt;
        sb.push_back(64'h0000_0001_0000_0007);
        md_op = MD_DIVU;
        md_rs = 32'd50;
        md_rt = 32'd7;
        md_start = 1'b1;
        hilo_read = 1'b1;
        #1 chk("stall_idle_start", 64'(md_stall), 64'd1);
        @(negedge clk);
        md_start = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            chk("stall_busy", 64'(md_stall), 64'(n <= 33));
            if (n == 33) begin
                e = sb.pop_front();
                chk("stall_op_write", 64'(wr), 64'd1);
                chk("stall_op_hi", 64'(data_high), 64'(e[63:32]));
                chk("stall_op_lo", 64'(data_low), 64'(e[31:0]));
            end
            md_start = (n == 5);
            if (n == 5) md_op = MD_MULTU;
            if (n < 34) @(negedge clk);
        end
        hilo_read = 1'b0;
        repeat (40) @(negedge clk);
        chk("busy_start_ignored", 64'(wr_cnt), 64'(base + 1));

        base = wr_cnt;
        md_op = MD_DIVU;
        md_rs = 32'd1000;
        md_rt = 32'd3;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(md_busy), 64'd0);
        chk("abort_write", 64'(wr), 64'd0);
        chk("abort_hi", 64'(data_high), 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_write", 64'(wr_cnt), 64'(base));
        chk("abort_idle_busy", 64'(md_busy), 64'd0);

        run_op("mult_small", MD_MULT, 32'd6, 32'd7, MUL_LAT, 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
